inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Instruction-cycle controller for the 8-bit core. Generates one-hot Q-phases clk1..clk4 that drive decode,
//  owns the program counter, prefetches one program word per instruction cycle into inst_reg,
//  and resolves control flow (GOTO/CALL/RETURN in class 2'b10, DECFSZ/INCFSZ skips) by flushing the prefetch.
// PARAMETERS
//  PC_W        8     program counter / prog_addr width
//  STACK_DEPTH 2     return-stack entries (>=1)
//  RESET_VEC   0     PC value after reset and after pop from empty stack
// PORTS
//  clk        in   1     system clock; all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  stall      in   1     1 = freeze phase, PC, inst_reg, stack this edge
//  prog_data  in   8     program memory read data for prog_addr (combinational, valid by Q4)
//  alu_zero   in   1     ALU result zero, sampled at Q4 for skip instructions
//  prog_addr  out  PC_W  program memory address (= PC)
//  inst_reg   out  8     instruction being executed this cycle, to decode
//  clk1..clk4 out  1 ea  one-hot phase Q1..Q4
//  flush      out  1     1 for whole cycle when inst_reg is a forced NOP
//  stack_err  out  1     sticky: stack overflow or underflow since reset
// BEHAVIOUR
//  Reset (async): clk1=1, clk2..4=0, PC=RESET_VEC, inst_reg=8'h00, flush=1, stack empty, stack_err=0.
//  Phase: Q1->Q2->Q3->Q4->Q1 one step per unstalled edge; exactly one of clk1..clk4 high at all times.
//  stall=1: no state changes (phase, PC, inst_reg, stack, flags); deassert resumes where frozen.
//  All sequencing happens on the edge leaving Q4 (the "Q4 edge"); other edges only advance phase.
//  Default Q4 edge: inst_reg<=prog_data, PC<=PC+1 (mod 2^PC_W, wraps), flush<=0. Latency 1 instr cycle.
//  Class 2'b10 (inst_reg[7:6]), op=inst_reg[5:4]; the prefetched word prog_data is the operand:
//   00 GOTO  : PC<=prog_data[PC_W-1:0] (zero-extend if PC_W>8), inst_reg<=8'h00, flush<=1.
//   01 CALL  : push PC+1 (addr after operand), then as GOTO.
//   10 RETURN: PC<=pop, inst_reg<=8'h00, flush<=1.
//   11 reserved: treated as single-word NOP (default Q4 edge).
//  Skip: inst_reg[7:6]=00 and inst_reg[5:2] in {1011,1111} and alu_zero=1 at Q4 edge:
//   inst_reg<=8'h00, PC<=PC+1, flush<=1 (fetched word discarded). alu_zero=0: default.
//  Flushed NOP 8'h00 never itself triggers skip/branch.
//  Stack: LIFO, pointer 0..STACK_DEPTH. Push when full: overwrites oldest (circular), stack_err<=1.
//  Pop when empty: returns RESET_VEC, pointer stays 0, stack_err<=1. stack_err clears only on reset.
//  Reset asserted mid-cycle: immediate return to reset state regardless of phase or stall.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds inputs step_mode(1), step(1). With step_mode=1, after each Q4 edge
//   the sequencer holds in Q1 (as if stalled) until an edge with step=1, then runs one full Q1..Q4 cycle.
//   step_mode=0 behaves exactly as without the macro; step ignored outside the Q1 hold; stall has priority.
//  Not defined: no extra ports; free-running per BEHAVIOUR.
// TESTING
//  1 Reset, prog mem {00:8'h1C,01:8'h08}, no stall -> clk1..4 rotate one-hot; at 1st Q4 edge inst_reg=1C,
//    PC=01, flush 1->0; at 2nd Q4 edge inst_reg=08, PC=02.
//  2 mem{00:8'h80,01:8'h40,40:8'h1C} (GOTO 40h) -> after GOTO cycle inst_reg=00, flush=1, PC=40;
//    next cycle inst_reg=1C.
//  3 CALL 20h at 05 (mem{05:8'h90,06:8'h20}), RETURN 8'hA0 at 20h -> push 07, PC=20; after RETURN PC=07,
//    stack empty, stack_err=0.
//  4 DECFSZ (8'h2C) with alu_zero=1 at Q4 -> next cycle flush=1, inst_reg=00, PC skips one word;
//    repeat with alu_zero=0 -> no flush.
//  5 STACK_DEPTH=2: three nested CALLs then three RETURNs -> stack_err=1 at 3rd push, 3rd RETURN
//    vectors to address of 2nd push target return? no: returns 2nd pushed value then RESET_VEC, err sticky.
//  6 stall=1 for 5 edges during Q2, then rst_n low during Q3 -> no change while stalled; reset state
//    immediately on rst_n fall; with SEQ_SINGLE_STEP_EN, step_mode=1 holds in Q1 until step pulse.

Source files
------------

// File: rtl/inst_sequencer.sv
// Q-phase instruction sequencer: PC, one-word prefetch, branch/skip flush, return stack.
// Optional single-step hold in Q1 when SEQ_SINGLE_STEP_EN is defined.
module inst_sequencer #(
    parameter int             PC_W        = 8,
    parameter int             STACK_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_VEC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    input  logic [7:0]      prog_data,
    input  logic            alu_zero,
    output logic [PC_W-1:0] prog_addr,
    output logic [7:0]      inst_reg,
    output logic            clk1,
    output logic            clk2,
    output logic            clk3,
    output logic            clk4,
    output logic            flush,
    output logic            stack_err
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        Q1 = 4'b0001,
        Q2 = 4'b0010,
        Q3 = 4'b0100,
        Q4 = 4'b1000
    } phase_e;

    phase_e                               phase_q, phase_d;
    logic [PC_W-1:0]                      pc_q, pc_d;
    logic [7:0]                           inst_q, inst_d;
    logic                                 flush_q, flush_d;
    logic                                 err_q, err_d;
    logic [SP_W-1:0]                      sp_q, sp_d;
    logic [STACK_DEPTH-1:0][PC_W-1:0]     stk_q, stk_d;

    logic            run;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic [PC_W+7:0] data_ext;
    logic [PC_W-1:0] pop_val;
    logic            is_br;
    logic            is_skip;
    logic [1:0]      op;

`ifdef SEQ_SINGLE_STEP_EN
    assign run = !stall && !(step_mode && (phase_q == Q1) && !step);
`else
    assign run = !stall;
`endif

    assign pc_inc   = pc_q + PC_W'(1);
    assign data_ext = {{PC_W{1'b0}}, prog_data};
    assign target   = data_ext[PC_W-1:0];
    assign op       = inst_q[5:4];
    // A flushed slot is always a plain NOP, never a branch or skip
    assign is_br    = !flush_q && (inst_q[7:6] == 2'b10);
    assign is_skip  = !flush_q && (inst_q[7:6] == 2'b00) && alu_zero &&
                      ((inst_q[5:2] == 4'b1011) || (inst_q[5:2] == 4'b1111));

    always_comb begin
        pop_val = RESET_VEC;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SP_W'(i + 1) == sp_q) pop_val = stk_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= Q1;
            pc_q    <= RESET_VEC;
            inst_q  <= 8'h00;
            flush_q <= 1'b1;
            err_q   <= 1'b0;
            sp_q    <= '0;
            stk_q   <= '0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
            stk_q   <= stk_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        flush_d = flush_q;
        err_d   = err_q;
        sp_d    = sp_q;
        stk_d   = stk_q;
        if (run) begin
            unique case (phase_q)
                Q1: phase_d = Q2;
                Q2: phase_d = Q3;
                Q3: phase_d = Q4;
                Q4: begin
                    phase_d = Q1;
                    inst_d  = prog_data;
                    pc_d    = pc_inc;
                    flush_d = 1'b0;
                    unique case (1'b1)
                        is_br && (op == 2'b00): begin
                            pc_d    = target;
                            inst_d  = 8'h00;
                            flush_d = 1'b1;
                        end
                        is_br && (op == 2'b01): begin
                            // Full stack drops its oldest entry
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                                    stk_d[i] = stk_q[i+1];
                                end
                                stk_d[STACK_DEPTH-1] = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < STACK_DEPTH; i++) begin
                                    if (SP_W'(i) == sp_q) stk_d[i] = pc_inc;
                                end
                                sp_d = sp_q + SP_W'(1);
                            end
                            pc_d    = target;
                            inst_d  = 8'h00;
                            flush_d = 1'b1;
                        end
                        is_br && (op == 2'b10): begin
                            if (sp_q == '0) begin
                                pc_d  = RESET_VEC;
                                err_d = 1'b1;
                            end else begin
                                pc_d = pop_val;
                                sp_d = sp_q - SP_W'(1);
                            end
                            inst_d  = 8'h00;
                            flush_d = 1'b1;
                        end
                        is_skip: begin
                            inst_d  = 8'h00;
                            flush_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: phase_d = Q1;
            endcase
        end
    end

    assign prog_addr = pc_q;
    assign inst_reg  = inst_q;
    assign clk1      = phase_q[0];
    assign clk2      = phase_q[1];
    assign clk3      = phase_q[2];
    assign clk4      = phase_q[3];
    assign flush     = flush_q;
    assign stack_err = err_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: phases, prefetch, GOTO/CALL/RETURN,
// skips, stack overflow/underflow, stall and asynchronous reset.
module tb_inst_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stall = 1'b0;
    logic       alu_zero = 1'b0;
    logic [7:0] prog_data;
    logic [7:0] prog_addr;
    logic [7:0] inst_reg;
    logic       clk1, clk2, clk3, clk4;
    logic       flush;
    logic       stack_err;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
`endif
    logic [7:0] mem [256];
    int         vecs = 0;
    int         errs = 0;

    inst_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .prog_data (prog_data),
        .alu_zero  (alu_zero),
        .prog_addr (prog_addr),
        .inst_reg  (inst_reg),
        .clk1      (clk1),
        .clk2      (clk2),
        .clk3      (clk3),
        .clk4      (clk4),
        .flush     (flush),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;
    assign prog_data = mem[prog_addr];

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [7:0] pc,
                      input logic [7:0] ir, input logic fl,
                      input logic er);
        chk({tag, ".ph"}, {28'd0, clk4, clk3, clk2, clk1}, 32'h1);
        chk({tag, ".pc"}, {24'd0, prog_addr}, {24'd0, pc});
        chk({tag, ".ir"}, {24'd0, inst_reg}, {24'd0, ir});
        chk({tag, ".fl"}, {31'd0, flush}, {31'd0, fl});
        chk({tag, ".er"}, {31'd0, stack_err}, {31'd0, er});
    endtask

    task automatic cyc();
        repeat (4) @(negedge clk);
    endtask

    task automatic clr();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset state, phase rotation, plain prefetch
        clr();
        mem[8'h00] = 8'h1C;
        mem[8'h01] = 8'h08;
        #1 rst_n = 1'b0;
        #1 st("rst", 8'h00, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ph2", {28'd0, clk4, clk3, clk2, clk1}, 32'h2);
        @(negedge clk);
        chk("ph3", {28'd0, clk4, clk3, clk2, clk1}, 32'h4);
        @(negedge clk);
        chk("ph4", {28'd0, clk4, clk3, clk2, clk1}, 32'h8);
        chk("ph4.fl", {31'd0, flush}, 32'h1);
        @(negedge clk);
        st("t1c1", 8'h01, 8'h1C, 1'b0, 1'b0);
        cyc();
        st("t1c2", 8'h02, 8'h08, 1'b0, 1'b0);

        // 2: GOTO 40h, then GOTO FFh with PC wrap
        clr();
        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'h40;
        mem[8'h40] = 8'h1C;
        do_reset();
        cyc();
        st("t2c1", 8'h01, 8'h80, 1'b0, 1'b0);
        cyc();
        st("t2c2", 8'h40, 8'h00, 1'b1, 1'b0);
        cyc();
        st("t2c3", 8'h41, 8'h1C, 1'b0, 1'b0);
        clr();
        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h1C;
        do_reset();
        cyc();
        cyc();
        st("wrap1", 8'hFF, 8'h00, 1'b1, 1'b0);
        cyc();
        st("wrap2", 8'h00, 8'h1C, 1'b0, 1'b0);

        // 3: CALL 20h from 05, RETURN to 07, then RETURN on empty stack
        clr();
        mem[8'h05] = 8'h90;
        mem[8'h06] = 8'h20;
        mem[8'h20] = 8'hA0;
        mem[8'h07] = 8'hA0;
        do_reset();
        repeat (6) cyc();
        st("t3pre", 8'h06, 8'h90, 1'b0, 1'b0);
        cyc();
        st("t3call", 8'h20, 8'h00, 1'b1, 1'b0);
        cyc();
        st("t3ret", 8'h21, 8'hA0, 1'b0, 1'b0);
        cyc();
        st("t3back", 8'h07, 8'h00, 1'b1, 1'b0);
        cyc();
        st("t3ret2", 8'h08, 8'hA0, 1'b0, 1'b0);
        cyc();
        st("t3undf", 8'h00, 8'h00, 1'b1, 1'b1);

        // 4: DECFSZ/INCFSZ skips and non-skips
        clr();
        mem[8'h00] = 8'h2C;
        mem[8'h01] = 8'h55;
        mem[8'h02] = 8'h3C;
        mem[8'h03] = 8'h77;
        mem[8'h04] = 8'h1C;
        alu_zero = 1'b0;
        do_reset();
        cyc();
        st("t4c1", 8'h01, 8'h2C, 1'b0, 1'b0);
        cyc();
        st("t4noskp", 8'h02, 8'h55, 1'b0, 1'b0);
        cyc();
        st("t4c3", 8'h03, 8'h3C, 1'b0, 1'b0);
        alu_zero = 1'b1;
        cyc();
        st("t4incsk", 8'h04, 8'h00, 1'b1, 1'b0);
        cyc();
        st("t4nop", 8'h05, 8'h1C, 1'b0, 1'b0);
        clr();
        mem[8'h00] = 8'h2C;
        mem[8'h01] = 8'h55;
        mem[8'h02] = 8'h1C;
        do_reset();
        cyc();
        st("t4d1", 8'h01, 8'h2C, 1'b0, 1'b0);
        cyc();
        st("t4decsk", 8'h02, 8'h00, 1'b1, 1'b0);
        cyc();
        st("t4d3", 8'h03, 8'h1C, 1'b0, 1'b0);
        alu_zero = 1'b0;

        // 5: three nested CALLs on a 2-deep stack, three RETURNs
        clr();
        mem[8'h00] = 8'h90;
        mem[8'h01] = 8'h10;
        mem[8'h10] = 8'h90;
        mem[8'h11] = 8'h20;
        mem[8'h20] = 8'h90;
        mem[8'h21] = 8'h30;
        mem[8'h30] = 8'hA0;
        mem[8'h22] = 8'hA0;
        mem[8'h12] = 8'hA0;
        do_reset();
        cyc();
        cyc();
        st("t5call1", 8'h10, 8'h00, 1'b1, 1'b0);
        cyc();
        cyc();
        st("t5call2", 8'h20, 8'h00, 1'b1, 1'b0);
        cyc();
        cyc();
        st("t5call3", 8'h30, 8'h00, 1'b1, 1'b1);
        cyc();
        cyc();
        st("t5ret1", 8'h22, 8'h00, 1'b1, 1'b1);
        cyc();
        cyc();
        st("t5ret2", 8'h12, 8'h00, 1'b1, 1'b1);
        cyc();
        cyc();
        st("t5ret3", 8'h00, 8'h00, 1'b1, 1'b1);
        cyc();
        st("t5after", 8'h01, 8'h90, 1'b0, 1'b1);

        // 6: stall freezes in Q2, resume, async reset mid-Q3 while stalled
        clr();
        mem[8'h00] = 8'hA0;
        do_reset();
        cyc();
        cyc();
        st("t6undf", 8'h00, 8'h00, 1'b1, 1'b1);
        cyc();
        st("t6pre", 8'h01, 8'hA0, 1'b0, 1'b1);
        @(negedge clk);
        stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stl.ph", {28'd0, clk4, clk3, clk2, clk1}, 32'h2);
            chk("stl.pc", {24'd0, prog_addr}, 32'h01);
            chk("stl.ir", {24'd0, inst_reg}, 32'hA0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume", {28'd0, clk4, clk3, clk2, clk1}, 32'h4);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 st("arst", 8'h00, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        chk("post", {28'd0, clk4, clk3, clk2, clk1}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
